// File: rtl/muldiv_seq_ctrl_if.sv
// Request/result handshake and shared-adder bus between the execute stage and
// the multiply/divide sequencer.
`timescale 1ns/1ps
interface muldiv_seq_ctrl_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_op;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic            kill;
   logic            res_valid;
   logic            res_ready;
   logic [XLEN-1:0] res_hi;
   logic [XLEN-1:0] res_lo;
   logic            add_cin;
   logic [XLEN-1:0] add_d1;
   logic [XLEN-1:0] add_d2;
   logic [XLEN-1:0] add_sum;
   logic            add_cout;

   // Execute stage plus the shared adder instance.
   modport master (
      output req_valid, req_op, req_a, req_b, kill, res_ready, add_sum, add_cout,
      input  req_ready, res_valid, res_hi, res_lo, add_cin, add_d1, add_d2
   );

   // The sequencer itself.
   modport slave (
      input  req_valid, req_op, req_a, req_b, kill, res_ready, add_sum, add_cout,
      output req_ready, res_valid, res_hi, res_lo, add_cin, add_d1, add_d2
   );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Radix-2 unsigned MULU/DIVU sequencer driving the core's shared 32-bit adder.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero skips the iteration phase.
`timescale 1ns/1ps
module muldiv_seq_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   muldiv_seq_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_t          state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            op_q, op_d;
   logic [XLEN-1:0] div_d1;
   logic            qbit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      opnd_d        = opnd_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      bus.req_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.add_cin   = 1'b0;
      bus.add_d1    = '0;
      bus.add_d2    = '0;
      // Partial remainder shifted left with the next dividend bit appended.
      div_d1        = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      qbit          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid && !bus.kill) begin
               op_d  = bus.req_op;
               cnt_d = '0;
               hi_d  = '0;
               if (bus.req_op) begin
                  lo_d   = bus.req_a;
                  opnd_d = bus.req_b;
`ifdef MULDIV_DIV0_FAST_EN
                  if (bus.req_b == '0) begin
                     hi_d    = bus.req_a;
                     lo_d    = '1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
`else
                  state_d = S_RUN;
`endif
               end else begin
                  lo_d    = bus.req_b;
                  opnd_d  = bus.req_a;
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            bus.add_d2 = opnd_q;
            if (op_q) begin
               // Restoring divide: a set top bit means the shifted remainder
               // exceeds XLEN bits, so the subtraction always fits.
               bus.add_cin = 1'b1;
               bus.add_d1  = div_d1;
               qbit        = hi_q[XLEN-1] | bus.add_cout;
            end else begin
               bus.add_d1 = hi_q;
            end

            if (bus.kill) begin
               state_d = S_IDLE;
            end else begin
               if (op_q) begin
                  hi_d = qbit ? bus.add_sum : div_d1;
                  lo_d = {lo_q[XLEN-2:0], qbit};
               end else if (lo_q[0]) begin
                  {hi_d, lo_d} = {bus.add_cout, bus.add_sum, lo_q[XLEN-1:1]};
               end else begin
                  {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            bus.res_valid = 1'b1;
            if (bus.kill || bus.res_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.res_hi = hi_q;
   assign bus.res_lo = lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: vector table, randomized ops against
// an arithmetic reference, plus handshake/kill/reset sequences.
`timescale 1ns/1ps
module tb_muldiv_seq_ctrl;
   localparam int XLEN = 32;
`ifdef MULDIV_DIV0_FAST_EN
   localparam bit FAST_DIV0 = 1'b1;
`else
   localparam bit FAST_DIV0 = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_seq_ctrl_if #(.XLEN(XLEN)) bus ();

   muldiv_seq_ctrl #(.XLEN(XLEN), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural model of the shared carry-lookahead adder.
   logic [XLEN:0] add_full;
   assign add_full = bus.add_cin ? ({1'b0, bus.add_d1} + {1'b0, ~bus.add_d2} + 33'd1)
                                 : ({1'b0, bus.add_d1} + {1'b0, bus.add_d2});
   assign bus.add_sum  = add_full[XLEN-1:0];
   assign bus.add_cout = add_full[XLEN];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input bit op, input logic [31:0] a, input logic [31:0] b);
      if (!op) return {32'h0, a} * {32'h0, b};
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   function automatic int exp_lat(input bit op, input logic [31:0] b);
      return (FAST_DIV0 && op && b == 32'h0) ? 0 : XLEN;
   endfunction

   task automatic issue_now(input bit op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      issue_now(op, a, b);
   endtask

   // lat counts clock edges after the accepting edge until res_valid is seen.
   task automatic wait_valid(output int lat, output bit busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      while (!bus.res_valid && lat < 200) begin
         if (bus.req_ready) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (bus.req_ready) busy_ok = 1'b0;
   endtask

   task automatic ack;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic run_and_check(input string name, input bit op, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp);
      int lat;
      bit busy_ok;
      issue(op, a, b);
      wait_valid(lat, busy_ok);
      check({name, ".lat"}, 64'(lat), 64'(exp_lat(op, b)));
      check({name, ".res"}, {bus.res_hi, bus.res_lo}, exp);
      check({name, ".busy"}, 64'(busy_ok), 64'd1);
      ack();
      check({name, ".idle"}, {62'h0, bus.req_ready, bus.res_valid}, 64'h2);
   endtask

   typedef struct {
      string       name;
      bit          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int lat;
      bit busy_ok, stable, fired;
      logic [31:0] h0, l0;

      tbl[0] = '{"mul7x6",    1'b0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A};
      tbl[1] = '{"mulmax",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      tbl[2] = '{"div100_7",  1'b1, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
      tbl[3] = '{"divtop",    1'b1, 32'h8000_0000, 32'd3,         64'h0000_0002_2AAA_AAAA};
      tbl[4] = '{"div0",      1'b1, 32'h1234_5678, 32'h0,         64'h1234_5678_FFFF_FFFF};
      tbl[5] = '{"mulzero",   1'b0, 32'h0,         32'h0001_2345, 64'h0};
      tbl[6] = '{"divsmall",  1'b1, 32'd5,         32'd9,         64'h0000_0005_0000_0000};
      tbl[7] = '{"divby1",    1'b1, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
      tbl[8] = '{"mul2p16",   1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

      bus.req_valid = 1'b0;
      bus.req_op    = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.kill      = 1'b0;
      bus.res_ready = 1'b0;

      #12;
      check("rst.ready_valid", {62'h0, bus.req_ready, bus.res_valid}, 64'h2);
      check("rst.res", {bus.res_hi, bus.res_lo}, 64'h0);
      check("rst.adder", {bus.add_cin, bus.add_d1, bus.add_d2}, 65'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_and_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

      for (int i = 0; i < 24; i++) begin
         bit op;
         logic [31:0] a, b;
         int sel;
         op  = 1'($urandom_range(0, 1));
         a   = $urandom;
         sel = $urandom_range(0, 5);
         b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
         run_and_check($sformatf("rnd%0d", i), op, a, b, ref_model(op, a, b));
      end

      // Result held while the consumer stalls, then back-to-back request.
      issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
      wait_valid(lat, busy_ok);
      check("hold.res", {bus.res_hi, bus.res_lo}, ref_model(1'b0, 32'hDEAD_BEEF, 32'h0000_1234));
      h0 = bus.res_hi;
      l0 = bus.res_lo;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!bus.res_valid || bus.res_hi !== h0 || bus.res_lo !== l0 || bus.req_ready) stable = 1'b0;
      end
      check("hold.stable", 64'(stable), 64'd1);
      ack();
      check("hold.idle_ready", 64'(bus.req_ready), 64'd1);
      issue_now(1'b1, 32'd1000, 32'd10);
      check("b2b.accepted", 64'(bus.req_ready), 64'd0);
      wait_valid(lat, busy_ok);
      check("b2b.lat", 64'(lat), 64'(XLEN));
      check("b2b.res", {bus.res_hi, bus.res_lo}, 64'h0000_0000_0000_0064);
      ack();

      // kill at cnt=10 of a MULU.
      issue(1'b0, 32'h0001_0001, 32'h0000_0003);
      repeat (10) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill.idle", {62'h0, bus.req_ready, bus.res_valid}, 64'h2);
      fired = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.res_valid) fired = 1'b1;
      end
      check("kill.no_result", 64'(fired), 64'd0);

      // kill in IDLE wins over req_valid.
      @(negedge clk);
      bus.kill = 1'b1;
      issue_now(1'b0, 32'd3, 32'd4);
      bus.kill = 1'b0;
      check("killidle.not_accepted", 64'(bus.req_ready), 64'd1);
      run_and_check("after_kill", 1'b0, 32'd12345, 32'd678, ref_model(1'b0, 32'd12345, 32'd678));

      // Asynchronous reset mid-DIVU.
      issue(1'b1, 32'hCAFE_F00D, 32'd3);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstrun.ready_valid", {62'h0, bus.req_ready, bus.res_valid}, 64'h2);
      check("rstrun.res", {bus.res_hi, bus.res_lo}, 64'h0);
      check("rstrun.adder", {bus.add_cin, bus.add_d1, bus.add_d2}, 65'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_and_check("after_rst", 1'b1, 32'hCAFE_F00D, 32'd3, ref_model(1'b1, 32'hCAFE_F00D, 32'd3));

      // Asynchronous reset while a result is waiting.
      issue(1'b0, 32'd9, 32'd9);
      wait_valid(lat, busy_ok);
      check("rstdone.pre", 64'(bus.res_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstdone.valid_drop", {62'h0, bus.req_ready, bus.res_valid}, 64'h2);
      @(negedge clk);
      rst_n = 1'b1;
      run_and_check("after_rst2", 1'b1, 32'd77, 32'd0, ref_model(1'b1, 32'd77, 32'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
